// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: MEM/WB->EX forwarding,
// load-use bubbles, MEM-stage redirect squash, memory-wait FSM with watchdog, perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs1_id_i,
  input  logic [REG_AW-1:0] rs2_id_i,
  input  logic [REG_AW-1:0] rs1_ex_i,
  input  logic [REG_AW-1:0] rs2_ex_i,
  input  logic [REG_AW-1:0] rd_ex_i,
  input  logic              mem_read_ex_i,
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic              reg_write_mem_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic              reg_write_wb_i,
  input  logic              redirect_mem_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_mem_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              flush_mem_o,
  output logic              mem_wait_o,
  output logic              error_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_count_o
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  // Memory handshake: dmem_req_i marks an access held in MEM; the access completes on
  // the first cycle dmem_ready_i is high (same cycle as the request, or any later one).
  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             mem_stall, load_use, redirect_apply;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (reg_write_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs)) return 2'b10;
    if (reg_write_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs))    return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    mem_stall      = 1'b0;
    load_use       = 1'b0;
    redirect_apply = 1'b0;
    forward_a_o    = 2'b00;
    forward_b_o    = 2'b00;
    stall_if_o     = 1'b0;
    stall_id_o     = 1'b0;
    stall_ex_o     = 1'b0;
    stall_mem_o    = 1'b0;
    flush_id_o     = 1'b0;
    flush_ex_o     = 1'b0;
    flush_mem_o    = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    error_d        = error_q;

    if (!rst_i) begin
      forward_a_o    = fwd_sel(rs1_ex_i);
      forward_b_o    = fwd_sel(rs2_ex_i);
      mem_stall      = (state_q == ST_WAIT) ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i);
      load_use       = mem_read_ex_i && (rd_ex_i != '0) &&
                       ((rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i));
      redirect_apply = redirect_mem_i && !mem_stall;

      // Priority: memory stall freezes everything, then redirect squashes any pending load-use.
      if (mem_stall) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
      end else if (redirect_apply) begin
        flush_id_o  = 1'b1;
        flush_ex_o  = 1'b1;
        flush_mem_o = 1'b1;
      end else if (load_use) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        flush_ex_o  = 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (dmem_req_i && !dmem_ready_i) begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end
        end
        ST_WAIT: begin
          if (dmem_ready_i) begin
            state_d = ST_RUN;
          end else begin
            // Watchdog only flags; the FSM keeps waiting for ready.
            if (wait_cnt_q != WCW'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_d == WCW'(MAX_WAIT)) error_d = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      error_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
      if (stall_if_o && (stall_cnt_q != '1))     stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_apply && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign mem_wait_o     = (state_q == ST_WAIT);
  assign error_o        = error_q;
  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;

endmodule
